// File: rtl/trig_sequencer.sv
// Trigger sequencer: masked OR/majority coincidence over a programmable window,
// prescale, fixed-width trigger pulse, dead time, and readout counters.
//
// state    | meaning
// S_IDLE   | disarmed, outputs low, config captured when arm rises
// S_READY  | armed, waiting for a first hit
// S_WINDOW | coincidence window open, accumulating hit channels
// S_FIRING | trigger pulse asserted
// S_DEAD   | dead time after the pulse, hits ignored
module trig_sequencer #(
    parameter int NCH = 4,
    parameter int CW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] chan_in,
    input  logic           arm,
    input  logic [NCH-1:0] cfg_mask,
    input  logic [3:0]     cfg_thresh,
    input  logic [7:0]     cfg_win,
    input  logic [7:0]     cfg_fire,
    input  logic [15:0]    cfg_dead,
    input  logic [7:0]     cfg_prescale,
    output logic           trig_out,
    output logic           busy,
    output logic           armed,
    output logic [CW-1:0]  trigger_count,
    output logic [CW-1:0]  cand_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_WINDOW,
        S_FIRING,
        S_DEAD
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] chan_q, chan_d;
    logic [NCH-1:0] acc_q, acc_d;
    logic [15:0]    tmr_q, tmr_d;
    logic [7:0]     pscnt_q, pscnt_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic [3:0]     thresh_q, thresh_d;
    logic [7:0]     win_q, win_d;
    logic [7:0]     fire_q, fire_d;
    logic [15:0]    dead_q, dead_d;
    logic [7:0]     prescale_q, prescale_d;
    logic           disarm_q, disarm_d;
    logic           trig_q, trig_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  tcnt_q, tcnt_d;
    logic [CW-1:0]  ccnt_q, ccnt_d;

    logic [NCH-1:0] hit;
    logic [3:0]     thr_eff;
    logic           qualify;
    logic           cand;
    logic [15:0]    fire_ld;
    logic [15:0]    dead_ld;
    logic [15:0]    win_ld;

    function automatic logic [4:0] popcnt(input logic [NCH-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NCH; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    assign hit     = chan_in & ~chan_q & mask_q;
    assign thr_eff = (thresh_q == 4'd0) ? 4'd1 : thresh_q;
    // A threshold above NCH can never be reached, so it simply never qualifies.
    assign qualify = (popcnt(acc_q | hit) >= {1'b0, thr_eff});
    assign fire_ld = (fire_q == 8'd0) ? 16'd0 : {8'd0, fire_q - 8'd1};
    assign dead_ld = dead_q - 16'd1;
    assign win_ld  = {8'd0, win_q - 8'd1};

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_in;
        acc_d      = acc_q;
        tmr_d      = tmr_q;
        pscnt_d    = pscnt_q;
        mask_d     = mask_q;
        thresh_d   = thresh_q;
        win_d      = win_q;
        fire_d     = fire_q;
        dead_d     = dead_q;
        prescale_d = prescale_q;
        disarm_d   = disarm_q;
        tcnt_d     = tcnt_q;
        ccnt_d     = ccnt_q;
        cand       = 1'b0;

        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                if (arm) begin
                    state_d    = S_READY;
                    mask_d     = cfg_mask;
                    thresh_d   = cfg_thresh;
                    win_d      = cfg_win;
                    fire_d     = cfg_fire;
                    dead_d     = cfg_dead;
                    prescale_d = cfg_prescale;
                end
            end
            S_READY: begin
                if (!arm) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                end else if (qualify) begin
                    cand = 1'b1;
                end else if ((hit != '0) && (win_q != 8'd0)) begin
                    state_d = S_WINDOW;
                    acc_d   = hit;
                    tmr_d   = win_ld;
                end
            end
            S_WINDOW: begin
                if (!arm) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                end else if (qualify) begin
                    cand = 1'b1;
                end else if (tmr_q == 16'd0) begin
                    state_d = S_READY;
                    acc_d   = '0;
                end else begin
                    acc_d = acc_q | hit;
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_FIRING: begin
                // A disarm anywhere in the pulse is remembered so the pulse finishes
                // at full width and then drops straight to IDLE.
                if (!arm) begin
                    disarm_d = 1'b1;
                end
                if (tmr_q == 16'd0) begin
                    disarm_d = 1'b0;
                    if (!arm || disarm_q) begin
                        state_d = S_IDLE;
                    end else if (dead_q == 16'd0) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_DEAD;
                        tmr_d   = dead_ld;
                    end
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            S_DEAD: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (tmr_q == 16'd0) begin
                    state_d = S_READY;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
            end
        endcase

        if (cand) begin
            ccnt_d = ccnt_q + CW'(1);
            acc_d  = '0;
            if (pscnt_q == prescale_q) begin
                pscnt_d  = 8'd0;
                tcnt_d   = tcnt_q + CW'(1);
                state_d  = S_FIRING;
                tmr_d    = fire_ld;
                disarm_d = 1'b0;
            end else begin
                pscnt_d = pscnt_q + 8'd1;
                state_d = S_READY;
            end
        end

        trig_d = (state_d == S_FIRING);
        busy_d = (state_d == S_FIRING) || (state_d == S_DEAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            chan_q     <= '0;
            acc_q      <= '0;
            tmr_q      <= '0;
            pscnt_q    <= '0;
            mask_q     <= '0;
            thresh_q   <= '0;
            win_q      <= '0;
            fire_q     <= '0;
            dead_q     <= '0;
            prescale_q <= '0;
            disarm_q   <= 1'b0;
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            tcnt_q     <= '0;
            ccnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            acc_q      <= acc_d;
            tmr_q      <= tmr_d;
            pscnt_q    <= pscnt_d;
            mask_q     <= mask_d;
            thresh_q   <= thresh_d;
            win_q      <= win_d;
            fire_q     <= fire_d;
            dead_q     <= dead_d;
            prescale_q <= prescale_d;
            disarm_q   <= disarm_d;
            trig_q     <= trig_d;
            busy_q     <= busy_d;
            tcnt_q     <= tcnt_d;
            ccnt_q     <= ccnt_d;
        end
    end

    assign trig_out      = trig_q;
    assign busy          = busy_q;
    assign armed         = (state_q != S_IDLE);
    assign trigger_count = tcnt_q;
    assign cand_count    = ccnt_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Bench for trig_sequencer: qualification table, directed timing sequences and
// randomized traffic against a time-stamp based reference model.
module tb_trig_sequencer;

    localparam int NCH = 4;
    localparam int CW  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           arm;
    logic [NCH-1:0] chan_in;
    logic [NCH-1:0] cfg_mask;
    logic [3:0]     cfg_thresh;
    logic [7:0]     cfg_win;
    logic [7:0]     cfg_fire;
    logic [15:0]    cfg_dead;
    logic [7:0]     cfg_prescale;
    logic           trig_out;
    logic           busy;
    logic           armed;
    logic [CW-1:0]  trigger_count;
    logic [CW-1:0]  cand_count;

    trig_sequencer #(.NCH(NCH), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .chan_in      (chan_in),
        .arm          (arm),
        .cfg_mask     (cfg_mask),
        .cfg_thresh   (cfg_thresh),
        .cfg_win      (cfg_win),
        .cfg_fire     (cfg_fire),
        .cfg_dead     (cfg_dead),
        .cfg_prescale (cfg_prescale),
        .trig_out     (trig_out),
        .busy         (busy),
        .armed        (armed),
        .trigger_count(trigger_count),
        .cand_count   (cand_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: tracks the pulse and dead time as absolute end cycles and
    // the coincidence window as an open flag plus its last admissible cycle.
    int          cyc        = 0;
    int          m_fire_end = -1;
    int          m_dead_end = -1;
    int          m_win_last = 0;
    bit          m_armed    = 0;
    bit          m_win_open = 0;
    bit          m_pend     = 0;
    logic [3:0]  m_acc      = '0;
    logic [3:0]  m_prev     = '0;
    logic [3:0]  l_mask     = '0;
    int          l_thr      = 1;
    int          l_win      = 0;
    int          l_fire     = 1;
    int          l_dead     = 0;
    int          l_ps       = 0;
    int          m_ps       = 0;
    logic [31:0] m_cand     = '0;
    logic [31:0] m_trig     = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [3:0] hit;
        logic [3:0] comb;
        if (rst) begin
            m_armed    = 0;
            m_win_open = 0;
            m_pend     = 0;
            m_acc      = '0;
            m_prev     = '0;
            m_ps       = 0;
            m_cand     = '0;
            m_trig     = '0;
            m_fire_end = cyc;
            m_dead_end = cyc;
        end else begin
            hit = chan_in & ~m_prev & l_mask;
            if (!m_armed) begin
                if (arm) begin
                    m_armed = 1;
                    l_mask  = cfg_mask;
                    l_thr   = (cfg_thresh == 0) ? 1 : int'(cfg_thresh);
                    l_win   = int'(cfg_win);
                    l_fire  = (cfg_fire == 0) ? 1 : int'(cfg_fire);
                    l_dead  = int'(cfg_dead);
                    l_ps    = int'(cfg_prescale);
                end
            end else if (cyc <= m_fire_end) begin
                if (!arm) m_pend = 1;
                if (cyc == m_fire_end && m_pend) begin
                    m_armed    = 0;
                    m_dead_end = cyc;
                end
            end else if (cyc <= m_dead_end) begin
                if (!arm) begin
                    m_armed    = 0;
                    m_dead_end = cyc;
                end
            end else if (!arm) begin
                m_armed    = 0;
                m_win_open = 0;
                m_acc      = '0;
            end else begin
                comb = (m_win_open ? m_acc : 4'd0) | hit;
                if (hit != 0 && $countones(comb) >= l_thr) begin
                    m_cand++;
                    m_win_open = 0;
                    m_acc      = '0;
                    if (m_ps == l_ps) begin
                        m_ps       = 0;
                        m_trig++;
                        m_fire_end = cyc + l_fire;
                        m_dead_end = m_fire_end + l_dead;
                        m_pend     = 0;
                    end else begin
                        m_ps++;
                    end
                end else if (m_win_open) begin
                    m_acc = comb;
                    if (cyc == m_win_last) begin
                        m_win_open = 0;
                        m_acc      = '0;
                    end
                end else if (hit != 0 && l_win != 0) begin
                    m_win_open = 1;
                    m_acc      = hit;
                    m_win_last = cyc + l_win;
                end
            end
            m_prev = chan_in;
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("trig_out", 64'(trig_out), 64'(cyc <= m_fire_end));
        chk("busy", 64'(busy), 64'(cyc <= m_dead_end));
        chk("armed", 64'(armed), 64'(m_armed));
        chk("trigger_count", 64'(trigger_count), 64'(m_trig));
        chk("cand_count", 64'(cand_count), 64'(m_cand));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rearm(input logic [3:0] mk, input logic [3:0] th, input logic [7:0] w,
                         input logic [7:0] f, input logic [15:0] d, input logic [7:0] ps);
        arm = 1'b0;
        for (int i = 0; i < 3000 && armed; i++) tick();
        chk("rearm_idle", 64'(armed), 64'd0);
        cfg_mask     = mk;
        cfg_thresh   = th;
        cfg_win      = w;
        cfg_fire     = f;
        cfg_dead     = d;
        cfg_prescale = ps;
        arm          = 1'b1;
        tick();
    endtask

    task automatic edge_on(input logic [3:0] ch);
        chan_in = ch;
        tick();
        chan_in = '0;
    endtask

    // Counts trig/busy cycles starting with the currently observed cycle.
    task automatic measure(input int n, output int tr, output int bz);
        tr = 0;
        bz = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            tr += int'(trig_out);
            bz += int'(busy);
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        logic [3:0] thresh;
        logic [3:0] pattern;
        logic       exp_fire;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          tr, bz;
        logic [31:0] c0, t0;

        vecs[0]  = '{4'hF, 4'd1, 4'h1, 1'b1};
        vecs[1]  = '{4'hF, 4'd0, 4'h2, 1'b1};
        vecs[2]  = '{4'hF, 4'd2, 4'h4, 1'b0};
        vecs[3]  = '{4'hF, 4'd2, 4'h5, 1'b1};
        vecs[4]  = '{4'hF, 4'd4, 4'hF, 1'b1};
        vecs[5]  = '{4'hF, 4'd5, 4'hF, 1'b0};
        vecs[6]  = '{4'h1, 4'd1, 4'h8, 1'b0};
        vecs[7]  = '{4'h3, 4'd2, 4'h7, 1'b1};
        vecs[8]  = '{4'h6, 4'd3, 4'hF, 1'b0};
        vecs[9]  = '{4'hF, 4'd3, 4'hB, 1'b1};
        vecs[10] = '{4'h0, 4'd1, 4'hF, 1'b0};

        rst = 1'b1; arm = 1'b0; chan_in = '0;
        cfg_mask = '0; cfg_thresh = '0; cfg_win = '0;
        cfg_fire = '0; cfg_dead = '0; cfg_prescale = '0;
        idle(3);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_count", 64'(trigger_count), 64'd0);
        rst = 1'b0;
        tick();

        // basic fire timing
        rearm(4'hF, 4'd1, 8'd0, 8'd4, 16'd20, 8'd0);
        idle(5);
        chk("basic_pre", 64'(trig_out), 64'd0);
        edge_on(4'h2);
        chk("basic_latency", 64'(trig_out), 64'd1);
        measure(40, tr, bz);
        chk("basic_trig_cycles", 64'(tr), 64'd4);
        chk("basic_busy_cycles", 64'(bz), 64'd24);
        chk("basic_tcount", 64'(trigger_count), 64'd1);
        chk("basic_ccount", 64'(cand_count), 64'd1);

        // qualification table
        for (int i = 0; i < 11; i++) begin
            rearm(vecs[i].mask, vecs[i].thresh, 8'd0, 8'd1, 16'd0, 8'd0);
            tick();
            c0 = cand_count;
            edge_on(vecs[i].pattern);
            chk($sformatf("vec%0d_trig", i), 64'(trig_out), 64'(vecs[i].exp_fire));
            chk($sformatf("vec%0d_cand", i), 64'(cand_count - c0), 64'(vecs[i].exp_fire));
            idle(3);
        end

        // coincidence window
        rearm(4'hF, 4'd2, 8'd5, 8'd4, 16'd20, 8'd0);
        t0 = trigger_count;
        edge_on(4'h1);
        idle(3);
        chk("win_pre", 64'(trig_out), 64'd0);
        edge_on(4'h4);
        chk("win_fire_at_4", 64'(trig_out), 64'd1);
        idle(30);
        edge_on(4'h1);
        idle(5);
        edge_on(4'h4);
        chk("win_expired_trig", 64'(trig_out), 64'd0);
        chk("win_expired_busy", 64'(busy), 64'd0);
        chk("win_expired_armed", 64'(armed), 64'd1);
        tick();
        edge_on(4'h2);
        chk("win_fresh_fire", 64'(trig_out), 64'd1);
        idle(30);
        chk("win_tdelta", 64'(trigger_count - t0), 64'd2);

        // masking and dead time
        rearm(4'h1, 4'd1, 8'd0, 8'd4, 16'd20, 8'd0);
        c0 = cand_count;
        t0 = trigger_count;
        for (int i = 0; i < 3; i++) begin
            edge_on(4'h8);
            idle(3);
        end
        chk("mask_no_cand", 64'(cand_count - c0), 64'd0);
        edge_on(4'h1);
        idle(9);
        edge_on(4'h1);
        idle(30);
        chk("dead_tdelta", 64'(trigger_count - t0), 64'd1);
        chk("dead_cdelta", 64'(cand_count - c0), 64'd1);

        // prescale
        rearm(4'hF, 4'd1, 8'd0, 8'd4, 16'd20, 8'd2);
        c0 = cand_count;
        t0 = trigger_count;
        for (int k = 0; k < 9; k++) begin
            edge_on(4'h2);
            chk($sformatf("prescale_cand%0d", k + 1), 64'(trig_out), 64'((k % 3) == 2));
            idle(30);
        end
        chk("prescale_cdelta", 64'(cand_count - c0), 64'd9);
        chk("prescale_tdelta", 64'(trigger_count - t0), 64'd3);

        // disarm mid-pulse; cfg change while armed is ignored until re-arm
        rearm(4'hF, 4'd1, 8'd0, 8'd8, 16'd20, 8'd0);
        cfg_fire = 8'd2;
        edge_on(4'h1);
        tr = int'(trig_out); bz = int'(busy);
        tick(); tr += int'(trig_out); bz += int'(busy);
        tick(); tr += int'(trig_out); bz += int'(busy);
        arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tr += int'(trig_out);
            bz += int'(busy);
        end
        chk("disarm_pulse_width", 64'(tr), 64'd8);
        chk("disarm_no_dead", 64'(bz), 64'd8);
        chk("disarm_armed", 64'(armed), 64'd0);
        rearm(4'hF, 4'd1, 8'd0, 8'd2, 16'd20, 8'd0);
        edge_on(4'h1);
        measure(40, tr, bz);
        chk("rearm_fire2_width", 64'(tr), 64'd2);

        // reset during dead time
        rearm(4'hF, 4'd1, 8'd0, 8'd4, 16'd20, 8'd0);
        edge_on(4'h4);
        idle(8);
        chk("dead_busy_before_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_trig", 64'(trig_out), 64'd0);
        chk("rst_tcount", 64'(trigger_count), 64'd0);
        chk("rst_ccount", 64'(cand_count), 64'd0);

        // arm high at reset release, fire=0, dead=0
        cfg_mask = 4'hF; cfg_thresh = 4'd1; cfg_win = 8'd0;
        cfg_fire = 8'd0; cfg_dead = 16'd0; cfg_prescale = 8'd0;
        arm = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("arm_at_release", 64'(armed), 64'd1);
        edge_on(4'h8);
        measure(10, tr, bz);
        chk("fire0_width", 64'(tr), 64'd1);
        chk("dead0_busy", 64'(bz), 64'd1);
        chk("dead0_ready", 64'(armed), 64'd1);

        // randomized traffic against the model
        for (int seg = 0; seg < 40; seg++) begin
            rearm(4'($urandom), 4'($urandom_range(0, 5)), 8'($urandom_range(0, 6)),
                  8'($urandom_range(0, 5)), 16'($urandom_range(0, 8)), 8'($urandom_range(0, 3)));
            for (int i = 0; i < 100; i++) begin
                chan_in = chan_in ^ (4'($urandom) & 4'($urandom));
                if (arm && $urandom_range(0, 59) == 0) arm = 1'b0;
                else if (!arm && $urandom_range(0, 7) == 0) arm = 1'b1;
                rst = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 49) == 0) begin
                    cfg_mask   = 4'($urandom);
                    cfg_thresh = 4'($urandom_range(0, 5));
                    cfg_fire   = 8'($urandom_range(0, 5));
                end
                tick();
            end
            rst = 1'b0;
            chan_in = '0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/trig_sequencer.md
Name: trig_sequencer

Overview:
- Configurable trigger controller for the trigger board's firing path. It takes the coax discriminator inputs, forms a masked OR/majority coincidence within a programmable window, and applies a prescale.
- It drives a fixed-width trigger pulse followed by a programmable dead time.
- It replaces hard-coded fire/dead constants with run-time configuration and adds trigger/candidate counters for readout.

Parameters:
- NCH, 4, number of trigger input channels (1..15)
- CW, 32, width of trigger_count and cand_count

Ports:
- clk  in  1  system clock (200 MHz, 5 ns/tick)
- rst  in  1  synchronous reset, active-high
- chan_in  in  NCH  discriminator inputs, level, already synchronous to clk
- arm  in  1  level; 1 = trigger enabled
- cfg_mask  in  NCH  per-channel enable
- cfg_thresh  in  4  minimum number of distinct channels for coincidence; 0 treated as 1
- cfg_win  in  8  coincidence window length in cycles after first hit
- cfg_fire  in  8  trigger pulse width in cycles; 0 treated as 1
- cfg_dead  in  16  dead time after pulse in cycles
- cfg_prescale  in  8  fire on every (cfg_prescale+1)-th candidate
- trig_out  out  1  trigger pulse
- busy  out  1  high in FIRING and DEAD
- armed  out  1  high when state is not IDLE
- trigger_count  out  CW  number of pulses fired, wraps
- cand_count  out  CW  number of qualified coincidences (pre-prescale), wraps

Behaviour:
- Reset:
  - Outputs: state=IDLE; trig_out=0, busy=0, armed=0, both counts=0.
  - Internal: prescale counter=0, hit accumulator=0, chan_in history=0.
- Config capture:
  - All cfg_* are latched on the IDLE->READY transition.
  - cfg changes while armed have no effect until the next re-arm.
- Hit detection:
  - chan_q is registered chan_in.
  - hit = chan_in & ~chan_q & mask_latched, i.e. rising edges only.
  - A held-high input produces one hit.
- Qualification: popcount(acc | hit) >= thresh_latched. If thresh > NCH, the block never qualifies.
- States:
  - IDLE:
    - Outputs low.
    - Go to READY when arm=1, latching cfg.
  - READY:
    - If hit != 0 and it qualifies: candidate.
    - Else if hit != 0: acc <= hit, wcnt <= 0, go to WINDOW; if win_latched=0, stay in READY and clear acc instead.
  - WINDOW:
    - acc <= acc | hit; wcnt++.
    - If it qualifies: candidate and clear acc.
    - Else if wcnt == win_latched-1: clear acc and go to READY. Total window = win_latched cycles after the first-hit cycle.
  - Candidate (from READY or WINDOW):
    - cand_count++.
    - If pscnt == prescale_latched: pscnt <= 0, fcnt <= 0, go to FIRING, trigger_count++.
    - Else: pscnt++, go to READY.
  - FIRING:
    - trig_out=1, busy=1 for exactly max(fire_latched,1) cycles.
    - Then go to DEAD, or to READY if dead_latched=0.
  - DEAD:
    - trig_out=0, busy=1 for exactly dead_latched cycles, then READY.
    - Hits in FIRING and DEAD are ignored and not accumulated.
- Latency: for an edge at cycle t (chan_in=1 at t, 0 at t-1) that qualifies alone, trig_out=1 from cycle t+1 inclusive.
- trig_out and busy are registered. No combinational path from chan_in to any output.
- Disarm:
  - arm=0 in READY, WINDOW or DEAD: go to IDLE next cycle and clear acc; pscnt is retained.
  - arm=0 in FIRING: the pulse completes its full width, then IDLE (no truncated pulses, no dead time).
  - arm=1 in IDLE with arm already high at reset release: READY on the first cycle after rst deasserts.
- Simultaneous events:
  - Qualification and window expiry in the same cycle: qualification wins.
  - Multiple channels rising in the same cycle count individually toward threshold.
- Counters wrap modulo 2^CW silently. rst mid-operation aborts any pulse immediately (trig_out=0 next cycle).

Test Plan:
- Basic fire timing:
  - Stimulus: NCH=4, mask=1111, thresh=1, fire=4, dead=20, prescale=0; arm, then pulse chan_in[1] at cycle 10.
  - Required: trig_out high cycles 11-14, busy high 11-34; trigger_count=1, cand_count=1.
- Coincidence window:
  - Stimulus: thresh=2, win=5; edge ch0 @10, ch2 @14.
  - Required: trig_out rises @15.
  - Repeat with ch2 @16: no trigger, state back in READY; the next single edge starts a fresh window.
- Masking and dead time:
  - Stimulus: mask=0001; edges on ch3 only.
  - Required: no candidates.
  - Then ch0 edges @10 and @20 with fire=4, dead=20: only one trigger (second edge falls in DEAD); trigger_count=1.
- Prescale:
  - Stimulus: prescale=2; 9 isolated qualifying edges spaced beyond fire+dead.
  - Required: cand_count=9, trigger_count=3, pulses on candidates 3, 6 and 9.
- Disarm mid-pulse:
  - Stimulus: fire=8; drop arm on the 3rd pulse cycle.
  - Required: full 8-cycle pulse, then armed=0 with no dead period.
  - Changed cfg_fire=2 takes effect only after re-arm.
- Reset and edge cases:
  - Stimulus: assert rst during DEAD.
  - Required: next cycle busy=0 and counts=0.
  - Also: fire=0 gives a 1-cycle pulse; dead=0 returns to READY directly after the pulse; thresh=5 with NCH=4 never fires.
